// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an N:1 data mux with minimum/maximum tenure
// and a one-cycle break-before-make gap between successive owners.
module rr_mux_arbiter #(
  parameter int N       = 4,
  parameter int W       = 1,
  parameter int HOLD    = 4,
  parameter int MAXHOLD = 16,
  localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           hz100,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [W-1:0]   out,
  output logic [N-1:0]   grant,
  output logic [SW-1:0]  sel,
  output logic           busy,
  output logic           preempt,
  output logic [1:0]     dbg_state_o
);

  localparam int CW = $clog2(MAXHOLD) + 1;
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAXHOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          arb_found;
  logic [SW-1:0] arb_idx;
  logic [N-1:0]  own_mask;
  logic          others_req;
  logic          vol_rel;
  logic          at_max;
  logic          preempt_c;

  // Handshake: req is a level held by the requester for as long as it wants
  // the channel; grant is the one-hot acknowledge, valid only while busy.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!arb_found && req[idx]) begin
        arb_found = 1'b1;
        arb_idx   = SW'(idx);
      end
    end
  end

  assign own_mask   = {{(N-1){1'b0}}, 1'b1} << sel_q;
  assign others_req = |(req & ~own_mask);
  // The owner may drop early, but tenure is never shorter than HOLD cycles.
  assign vol_rel    = !req[sel_q] && (cnt_q >= HOLD_M1);
  assign at_max     = (cnt_q == MAX_M1);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_c = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (arb_found) begin
          state_d = GRANT;
          sel_d   = arb_idx;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (vol_rel || (at_max && others_req)) begin
          state_d   = GAP;
          ptr_d     = (int'(sel_q) == N - 1) ? '0 : sel_q + 1'b1;
          cnt_d     = '0;
          preempt_c = !vol_rel;
        end else if (at_max) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registered state, so an async reset clears them at once.
  assign busy        = (state_q == GRANT);
  assign grant       = busy ? own_mask : '0;
  assign out         = busy ? data[sel_q*W +: W] : '0;
  assign sel         = sel_q;
  assign preempt     = preempt_c;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: vector table for short grants and pointer wrap,
// plus hand sequences for contention, long uncontested hold and async reset.
module tb_rr_mux_arbiter;

  localparam int N       = 4;
  localparam int W       = 1;
  localparam int HOLD    = 4;
  localparam int MAXHOLD = 16;
  localparam int SW      = 2;
  localparam int EW      = 2 + SW + N + W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic           hz100 = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] data  = '0;
  logic [W-1:0]   out;
  logic [N-1:0]   grant;
  logic [SW-1:0]  sel;
  logic           busy;
  logic           preempt;
  logic [1:0]     dbg_state;

  rr_mux_arbiter #(.N(N), .W(W), .HOLD(HOLD), .MAXHOLD(MAXHOLD)) dut (
    .hz100       (hz100),
    .reset       (reset),
    .req         (req),
    .data        (data),
    .out         (out),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .preempt     (preempt),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 hz100 = ~hz100;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [EW-1:0]  exp;
  } vec_t;

  vec_t tbl[19];

  // Expected observable vector: {state, sel, grant, out, busy, preempt}.
  function automatic logic [EW-1:0] mk(input logic [1:0] st, input logic [SW-1:0] s,
                                       input logic [W-1:0] o, input logic pe);
    logic [N-1:0] g;
    logic [W-1:0] ov;
    logic         b;
    b  = (st == S_GRANT);
    g  = b ? (N'(1) << s) : '0;
    ov = b ? o : '0;
    return {st, s, g, ov, b, pe};
  endfunction

  task automatic check(input string name);
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    e = exp_q.pop_front();
    a = {dbg_state, sel, grant, out, busy, preempt};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got {st,sel,grant,out,busy,pre}=%b required %b", name, a, e);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d,
                      input logic [EW-1:0] e, input string name);
    @(negedge hz100);
    req  = r;
    data = d;
    exp_q.push_back(e);
    #1;
    check(name);
  endtask

  task automatic do_reset();
    @(negedge hz100);
    reset = 1'b0;
    req   = '0;
    @(negedge hz100);
    reset = 1'b1;
  endtask

  initial begin
    logic [N*W-1:0] d;
    int o;

    // reset held with random requests
    for (int i = 0; i < 3; i++)
      step(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
           mk(S_IDLE, 0, 0, 0), $sformatf("reset_hold%0d", i));
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < 2; i++)
      step('0, '0, mk(S_IDLE, 0, 0, 0), $sformatf("post_reset_idle%0d", i));

    // short single request, then ptr=3 wrap to 0 and handover to 1
    tbl[0]  = '{4'b0100, 4'b0100, mk(S_IDLE,  0, 0, 0)};
    tbl[1]  = '{4'b0000, 4'b0100, mk(S_GRANT, 2, 1, 0)};
    tbl[2]  = '{4'b0000, 4'b0100, mk(S_GRANT, 2, 1, 0)};
    tbl[3]  = '{4'b0000, 4'b0100, mk(S_GRANT, 2, 1, 0)};
    tbl[4]  = '{4'b0000, 4'b0100, mk(S_GRANT, 2, 1, 0)};
    tbl[5]  = '{4'b0000, 4'b0100, mk(S_GAP,   2, 0, 0)};
    tbl[6]  = '{4'b0000, 4'b0100, mk(S_IDLE,  2, 0, 0)};
    tbl[7]  = '{4'b0011, 4'b0001, mk(S_IDLE,  2, 0, 0)};
    tbl[8]  = '{4'b0010, 4'b0001, mk(S_GRANT, 0, 1, 0)};
    tbl[9]  = '{4'b0010, 4'b0001, mk(S_GRANT, 0, 1, 0)};
    tbl[10] = '{4'b0010, 4'b0001, mk(S_GRANT, 0, 1, 0)};
    tbl[11] = '{4'b0010, 4'b0001, mk(S_GRANT, 0, 1, 0)};
    tbl[12] = '{4'b0010, 4'b0001, mk(S_GAP,   0, 0, 0)};
    tbl[13] = '{4'b0000, 4'b0001, mk(S_GRANT, 1, 0, 0)};
    tbl[14] = '{4'b0000, 4'b0001, mk(S_GRANT, 1, 0, 0)};
    tbl[15] = '{4'b0000, 4'b0001, mk(S_GRANT, 1, 0, 0)};
    tbl[16] = '{4'b0000, 4'b0001, mk(S_GRANT, 1, 0, 0)};
    tbl[17] = '{4'b0000, 4'b0001, mk(S_GAP,   1, 0, 0)};
    tbl[18] = '{4'b0000, 4'b0001, mk(S_IDLE,  1, 0, 0)};
    for (int i = 0; i < 19; i++)
      step(tbl[i].req, tbl[i].data, tbl[i].exp, $sformatf("table%0d", i));

    // full contention: 0,1,2,3,0 each MAXHOLD cycles, preempt on the last
    do_reset();
    step(4'b1111, '0, mk(S_IDLE, 0, 0, 0), "cont_idle");
    for (int g = 0; g < 5; g++) begin
      o = g % N;
      for (int c = 0; c < MAXHOLD; c++) begin
        d = N'($urandom_range(0, 15));
        step(4'b1111, d, mk(S_GRANT, SW'(o), d[o], (c == MAXHOLD - 1)),
             $sformatf("cont_g%0d_c%0d", g, c));
      end
      if (g < 4) step(4'b1111, '0, mk(S_GAP, SW'(o), 0, 0), $sformatf("cont_gap%0d", g));
    end

    // uncontested hold: counter rolls without release or preempt
    do_reset();
    step(4'b0001, '0, mk(S_IDLE, 0, 0, 0), "long_idle");
    for (int c = 1; c < 40; c++) begin
      d = N'($urandom_range(0, 15));
      step(4'b0001, d, mk(S_GRANT, 0, d[0], 0), $sformatf("long_c%0d", c));
    end
    step('0, 4'b0001, mk(S_GRANT, 0, 1, 0), "long_last");
    step('0, 4'b0001, mk(S_GAP,   0, 0, 0), "long_gap");
    step('0, 4'b0001, mk(S_IDLE,  0, 0, 0), "long_idle_end");

    // async reset in the 5th grant cycle, then ptr restarts at 0
    do_reset();
    step(4'b0100, 4'b0100, mk(S_IDLE, 0, 0, 0), "rmid_idle");
    for (int c = 1; c <= 5; c++)
      step(4'b0100, 4'b0100, mk(S_GRANT, 2, 1, 0), $sformatf("rmid_g%0d", c));
    #1;
    reset = 1'b0;
    exp_q.push_back(mk(S_IDLE, 0, 0, 0));
    #1;
    check("rmid_async");
    @(negedge hz100);
    reset = 1'b1;
    req   = 4'b1000;
    data  = 4'b1000;
    exp_q.push_back(mk(S_IDLE, 0, 0, 0));
    #1;
    check("rmid_release");
    for (int c = 0; c < HOLD; c++)
      step('0, 4'b1000, mk(S_GRANT, 3, 1, 0), $sformatf("rmid_g3_%0d", c));
    step('0, 4'b1000, mk(S_GAP,  3, 0, 0), "rmid_gap");
    step('0, 4'b1000, mk(S_IDLE, 3, 0, 0), "rmid_idle_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
